ram_dual_read_clear: RTL
========================

Name: ram_dual_read_clear

Overview:
Parametrised simple-dual-port RAM with one write port and two independent synchronous read ports (A, B), intended as the processor's register-file/scratch storage successor. Adds:
- selectable read latency (1 or 2 cycles)
- optional write-to-read bypass
- out-of-range address detection
- a hardware clear sequencer that zeroes the whole array, on request or on reset, with a busy indication.

Parameters:
DATA_WIDTH, 8, width of each word.
ADDR_WIDTH, 10, width of all address ports.
MEM_SIZE, 10, number of words; legal addresses 0..MEM_SIZE-1 (MEM_SIZE <= 2**ADDR_WIDTH).
READ_LATENCY, 1, 1 = registered read; 2 = one extra output register stage.
BYPASS, 1, 1 = write-first on same-address read/write; 0 = read-first (old data).
CLEAR_ON_RESET, 1, 1 = Reset launches a clear sweep; 0 = Reset does not touch the array.

Ports:
Clock  input  1  single clock, all state on rising edge.
Reset  input  1  synchronous, active-high.
iClear  input  1  request array clear; sampled only in IDLE.
iWriteEnable  input  1  write strobe.
iWriteAddress  input  ADDR_WIDTH  write address.
iDataIn  input  DATA_WIDTH  write data.
iReadAddressA  input  ADDR_WIDTH  read address, port A.
iReadAddressB  input  ADDR_WIDTH  read address, port B.
oDataOutA  output  DATA_WIDTH  read data, port A (registered).
oDataOutB  output  DATA_WIDTH  read data, port B (registered).
oBusy  output  1  high while clear sweep in progress (registered).
oAddrError  output  1  one-cycle pulse: illegal address used on the previous edge (registered).

Behaviour:
- Reset (sampled high at edge):
  - oDataOutA/B, all pipeline stages and oAddrError go to 0.
  - CLEAR_ON_RESET=1: state<=CLEAR, counter<=0, oBusy<=1.
  - CLEAR_ON_RESET=0: state<=IDLE, oBusy<=0; array contents unchanged.
  - Reset mid-sweep restarts (CLEAR_ON_RESET=1) or aborts (=0) the sweep.
  - No write occurs on a Reset edge.
- FSM states: IDLE, CLEAR.
  - IDLE, iClear=1: state<=CLEAR, counter<=0, oBusy<=1. A write presented on that same edge is still performed.
  - CLEAR: each edge writes Ram[counter]<=0, counter++. On the edge where counter==MEM_SIZE-1: final write, state<=IDLE, oBusy<=0. oBusy is therefore high for exactly MEM_SIZE cycles.
  - iClear is ignored in CLEAR (no restart).
  - External writes in CLEAR are dropped silently.
- Write (IDLE only): iWriteEnable=1 and iWriteAddress<MEM_SIZE gives Ram[iWriteAddress]<=iDataIn. Address >= MEM_SIZE: no array change, error flagged.
- Read: each port is independent; both may use the same address.
  - READ_LATENCY=1: address at edge N, data on oDataOut from edge N.
  - READ_LATENCY=2: data from edge N+1.
  - Out-of-range read address returns 0 and flags error.
  - In CLEAR state, both ports return 0 regardless of address.
- Same-edge write/read collision (IDLE, legal write, read addr == write addr):
  - BYPASS=1: that port returns iDataIn.
  - BYPASS=0: that port returns the pre-write word.
  - Applies per port; A and B may both hit.
- oAddrError: at each non-reset edge, <=1 if (accepted-state write with illegal address) or (either read address illegal while IDLE), else 0. Latency is 1 cycle independent of READ_LATENCY.
- Array has no implicit reset other than the clear sweep.

Test Plan:
1. Reset with CLEAR_ON_RESET=1, MEM_SIZE=10 -> oBusy high exactly 10 cycles, outputs 0 throughout. Afterwards, reading addresses 0..9 on A and B returns 0x00.
2. Write 0x5A@3, 0xC3@7; read A=3, B=7 next cycle -> oDataOutA=0x5A, oDataOutB=0xC3 after 1 edge (READ_LATENCY=1) or 2 edges (READ_LATENCY=2).
3. Addr 4 holds 0x11; same edge write 0x22@4 with A=B=4 -> outputs 0x22 with BYPASS=1, 0x11 with BYPASS=0; a following read gives 0x22 in both cases.
4. Write 0xFF@12 (MEM_SIZE=10) -> oAddrError=1 for one cycle, addresses 0..9 unchanged. Read A=15 -> oDataOutA=0, oAddrError pulse.
5. Fill 0..9 with 0xA0+i, assert iClear, then during the sweep attempt write 0x77@2 and iClear again -> oBusy high 10 cycles without restart; all words 0x00 after the sweep, including addr 2.
6. Assert Reset at cycle 4 of a sweep (CLEAR_ON_RESET=1) -> oBusy stays high a further 10 cycles from the reset edge; all words 0 afterwards. With CLEAR_ON_RESET=0 -> oBusy drops on the reset edge and words 4..9 keep their old values.

Source files
------------

// File: rtl/ram_dual_read_clear.sv
// ram_dual_read_clear
// Simple-dual-port RAM: one write port, two independent synchronous read
// ports (A, B). Adds a selectable read latency (1 or 2), an optional
// write-first bypass, out-of-range address detection and a clear sequencer
// that zeroes the whole array on request (and optionally on reset).
//
// Ports:
//   Clock          - single clock, all state on the rising edge
//   Reset          - synchronous, active-high
//   iClear         - request an array clear sweep (honoured only in IDLE)
//   iWriteEnable   - write strobe
//   iWriteAddress  - write address
//   iDataIn        - write data
//   iReadAddressA  - read address, port A
//   iReadAddressB  - read address, port B
//   oDataOutA      - registered read data, port A
//   oDataOutB      - registered read data, port B
//   oBusy          - high while the clear sweep runs (MEM_SIZE cycles)
//   oAddrError     - one-cycle pulse: illegal address used on previous edge
module ram_dual_read_clear #(
  parameter int DATA_WIDTH     = 8,
  parameter int ADDR_WIDTH     = 10,
  parameter int MEM_SIZE       = 10,
  parameter int READ_LATENCY   = 1,
  parameter int BYPASS         = 1,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  iClear,
  input  logic                  iWriteEnable,
  input  logic [ADDR_WIDTH-1:0] iWriteAddress,
  input  logic [DATA_WIDTH-1:0] iDataIn,
  input  logic [ADDR_WIDTH-1:0] iReadAddressA,
  input  logic [ADDR_WIDTH-1:0] iReadAddressB,
  output logic [DATA_WIDTH-1:0] oDataOutA,
  output logic [DATA_WIDTH-1:0] oDataOutB,
  output logic                  oBusy,
  output logic                  oAddrError
);

  // Index width covers exactly MEM_SIZE entries; addresses are range-checked
  // on the full width before the truncated index is ever used.
  localparam int IDX_W = (MEM_SIZE > 1) ? $clog2(MEM_SIZE) : 1;
  // One extra bit so MEM_SIZE == 2**ADDR_WIDTH is representable.
  localparam logic [ADDR_WIDTH:0]   SIZE_C = (ADDR_WIDTH+1)'(MEM_SIZE);
  localparam logic [ADDR_WIDTH-1:0] LAST_C = ADDR_WIDTH'(MEM_SIZE - 1);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   cnt_q, cnt_d;
  logic                    busy_q, busy_d;
  logic                    err_q;
  logic                    wr_ok;
  logic [DATA_WIDTH-1:0]   mem [MEM_SIZE];
  logic [DATA_WIDTH-1:0]   rd_a_p0, rd_b_p0;

  function automatic logic addr_ok(input logic [ADDR_WIDTH-1:0] a);
    return {1'b0, a} < SIZE_C;
  endfunction

  // Value a read port captures this edge: zero while sweeping or when the
  // address is illegal; the incoming write data on a same-address hit when
  // write-first is selected; otherwise the stored (pre-write) word.
  function automatic logic [DATA_WIDTH-1:0] read_port(input logic [ADDR_WIDTH-1:0] a);
    if (state_q != IDLE || !addr_ok(a))
      return '0;
    if (BYPASS != 0 && wr_ok && a == iWriteAddress)
      return iDataIn;
    return mem[a[IDX_W-1:0]];
  endfunction

  assign wr_ok = (state_q == IDLE) && iWriteEnable && addr_ok(iWriteAddress);

  // Clear sequencer: next-state logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    case (state_q)
      IDLE: begin
        if (iClear) begin
          state_d = CLEAR;
          cnt_d   = '0;
          busy_d  = 1'b1;
        end
      end
      CLEAR: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_C) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= (CLEAR_ON_RESET != 0) ? CLEAR : IDLE;
      cnt_q   <= '0;
      busy_q  <= (CLEAR_ON_RESET != 0);
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
    end
  end

  // Array write: sweep has priority; external writes only land in IDLE.
  // Nothing is written on a reset edge.
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      if (state_q == CLEAR)
        mem[cnt_q[IDX_W-1:0]] <= '0;
      else if (wr_ok)
        mem[iWriteAddress[IDX_W-1:0]] <= iDataIn;
    end
  end

  // Stage p0: registered read and address-error flag
  always_ff @(posedge Clock) begin
    if (Reset) begin
      rd_a_p0 <= '0;
      rd_b_p0 <= '0;
      err_q   <= 1'b0;
    end else begin
      rd_a_p0 <= read_port(iReadAddressA);
      rd_b_p0 <= read_port(iReadAddressB);
      err_q   <= (state_q == IDLE) &&
                 ((iWriteEnable && !addr_ok(iWriteAddress)) ||
                  !addr_ok(iReadAddressA) || !addr_ok(iReadAddressB));
    end
  end

  // Stage p1: optional extra output register
  generate
    if (READ_LATENCY == 2) begin : g_lat2
      logic [DATA_WIDTH-1:0] rd_a_p1, rd_b_p1;
      always_ff @(posedge Clock) begin
        if (Reset) begin
          rd_a_p1 <= '0;
          rd_b_p1 <= '0;
        end else begin
          rd_a_p1 <= rd_a_p0;
          rd_b_p1 <= rd_b_p0;
        end
      end
      assign oDataOutA = rd_a_p1;
      assign oDataOutB = rd_b_p1;
    end else begin : g_lat1
      assign oDataOutA = rd_a_p0;
      assign oDataOutB = rd_b_p0;
    end
  endgenerate

  assign oBusy      = busy_q;
  assign oAddrError = err_q;

endmodule
